pri_rr_sched: RTL and testbench

//  Shares one downstream resource among WIDTH requesters. Grant selection uses the
//  MSB-first log-tree leading-one encoder: the highest requesting index wins. A rotating

---
 rtl/pri_sched_pkg.sv | 15 +
 rtl/msb_encoder.sv | 43 ++++
 rtl/pri_rr_sched.sv | 148 ++++++++++++++
 tb/tb_pri_rr_sched.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pri_sched_pkg.sv
// Purpose : shared defaults and FSM encoding for the priority round-robin scheduler.
// Contents: requester count / index width / hold limit defaults, scheduler state enum.
// Users   : pri_rr_sched (top) and the bench.
package pri_sched_pkg;

    localparam int DEF_WIDTH     = 56;
    localparam int DEF_WIDTH_LOG = 6;
    localparam int DEF_MAX_HOLD  = 15;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } sched_state_t;

endpackage

// File: rtl/msb_encoder.sv
// Purpose : combinational leading-one (highest set bit) encoder built as a binary log tree.
// Latency : purely combinational, log2(WIDTH) mux levels.
// Ports   : vec (in, WIDTH) -> idx (out, WIDTH_LOG) index of highest set bit, any (out) vec != 0.
module msb_encoder #(
    parameter int WIDTH     = 56,
    parameter int WIDTH_LOG = 6
) (
    input  logic [WIDTH-1:0]     vec,
    output logic [WIDTH_LOG-1:0] idx,
    output logic                 any
);

    // The tree works on a power-of-two width; padding bits are tied low so the
    // result can never point at an index >= WIDTH.
    localparam int N = 1 << WIDTH_LOG;

    // Level l holds N>>l nodes; each node carries a valid flag and the index of
    // the highest set bit found beneath it. Unused upper entries stay zero.
    logic [WIDTH_LOG:0][N-1:0]                lvl_vld;
    logic [WIDTH_LOG:0][N-1:0][WIDTH_LOG-1:0] lvl_idx;

    always_comb begin
        lvl_vld = '0;
        lvl_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            lvl_vld[0][i] = vec[i];
        end
        for (int i = 0; i < N; i++) begin
            lvl_idx[0][i] = WIDTH_LOG'(i);
        end
        for (int l = 0; l < WIDTH_LOG; l++) begin
            for (int j = 0; j < (N >> (l + 1)); j++) begin
                // Upper half wins whenever it has any bit set.
                lvl_vld[l+1][j] = lvl_vld[l][2*j+1] | lvl_vld[l][2*j];
                lvl_idx[l+1][j] = lvl_vld[l][2*j+1] ? lvl_idx[l][2*j+1] : lvl_idx[l][2*j];
            end
        end
    end

    assign idx = lvl_idx[WIDTH_LOG][0];
    assign any = lvl_vld[WIDTH_LOG][0];

endmodule

// File: rtl/pri_rr_sched.sv
// Purpose : arbitrates one resource among WIDTH requesters; highest index wins, a rotating
//           mask adds round-robin fairness, grants held until release / req drop / hold limit.
// Latency : request sampled at a clock edge appears as a registered grant right after that
//           edge; grant hand-over is back-to-back with no idle cycle.
// Ports   : clk, rst_n (async active-low), req[WIDTH], release_gnt (the "release" strobe,
//           renamed because release is a reserved word), gnt[WIDTH] one-hot,
//           gnt_id[WIDTH_LOG], gnt_valid, timeout (1-cycle pulse on forced revoke).
module pri_rr_sched
    import pri_sched_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int WIDTH_LOG = DEF_WIDTH_LOG,
    parameter int MAX_HOLD  = DEF_MAX_HOLD
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     req,
    input  logic                 release_gnt,
    output logic [WIDTH-1:0]     gnt,
    output logic [WIDTH_LOG-1:0] gnt_id,
    output logic                 gnt_valid,
    output logic                 timeout
);

    localparam int                HOLD_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    sched_state_t         state, state_nxt;
    logic [WIDTH-1:0]     mask, mask_nxt;
    logic [HOLD_W-1:0]    hold_cnt, hold_cnt_nxt;
    logic [WIDTH-1:0]     gnt_nxt;
    logic [WIDTH_LOG-1:0] gnt_id_nxt;
    logic                 gnt_valid_nxt;
    logic                 timeout_nxt;

    // Mask that takes effect when the current grant ends: only indices below
    // the ending requester are preferred. gnt_id == 0 yields an empty mask,
    // which drops arbitration back to plain highest-index priority.
    logic [WIDTH-1:0]     end_mask;
    logic [WIDTH-1:0]     arb_mask;
    logic [WIDTH-1:0]     masked_req;
    logic [WIDTH_LOG-1:0] masked_idx, full_idx, sel;
    logic                 masked_any, full_any;

    logic                 implicit_rel;
    logic                 hold_limit;
    logic                 grant_end;

    assign end_mask = (WIDTH'(1) << gnt_id) - WIDTH'(1);

    // In GRANT the only arbitration result that is ever used is the hand-over
    // at the end of the grant, so the post-grant mask is applied directly.
    assign arb_mask   = (state == GRANT) ? end_mask : mask;
    assign masked_req = req & arb_mask;

    msb_encoder #(
        .WIDTH     (WIDTH),
        .WIDTH_LOG (WIDTH_LOG)
    ) u_enc_masked (
        .vec (masked_req),
        .idx (masked_idx),
        .any (masked_any)
    );

    msb_encoder #(
        .WIDTH     (WIDTH),
        .WIDTH_LOG (WIDTH_LOG)
    ) u_enc_full (
        .vec (req),
        .idx (full_idx),
        .any (full_any)
    );

    assign sel = masked_any ? masked_idx : full_idx;

    assign implicit_rel = ~req[gnt_id];
    assign hold_limit   = (hold_cnt == HOLD_LAST);
    assign grant_end    = release_gnt | implicit_rel | hold_limit;

    always_comb begin
        state_nxt     = state;
        mask_nxt      = mask;
        hold_cnt_nxt  = hold_cnt;
        gnt_nxt       = gnt;
        gnt_id_nxt    = gnt_id;
        gnt_valid_nxt = gnt_valid;
        timeout_nxt   = 1'b0;

        unique case (state)
            IDLE: begin
                if (full_any) begin
                    state_nxt     = GRANT;
                    gnt_nxt       = WIDTH'(1) << sel;
                    gnt_id_nxt    = sel;
                    gnt_valid_nxt = 1'b1;
                    hold_cnt_nxt  = '0;
                end
            end
            GRANT: begin
                hold_cnt_nxt = hold_cnt + HOLD_W'(1);
                if (grant_end) begin
                    mask_nxt    = end_mask;
                    // A release (explicit or via dropped req) on the limit cycle
                    // is an ordinary release, not a forced revoke.
                    timeout_nxt = hold_limit & ~release_gnt & ~implicit_rel;
                    if (full_any) begin
                        // Hand over at the same edge; the ending requester can
                        // win again only if nothing below it is requesting.
                        gnt_nxt       = WIDTH'(1) << sel;
                        gnt_id_nxt    = sel;
                        gnt_valid_nxt = 1'b1;
                        hold_cnt_nxt  = '0;
                    end else begin
                        state_nxt     = IDLE;
                        gnt_nxt       = '0;
                        gnt_id_nxt    = '0;
                        gnt_valid_nxt = 1'b0;
                        hold_cnt_nxt  = '0;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mask      <= '1;
            hold_cnt  <= '0;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_nxt;
            mask      <= mask_nxt;
            hold_cnt  <= hold_cnt_nxt;
            gnt       <= gnt_nxt;
            gnt_id    <= gnt_id_nxt;
            gnt_valid <= gnt_valid_nxt;
            timeout   <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_pri_rr_sched.sv
// Purpose : directed self-checking bench for pri_rr_sched (reset, priority, round-robin,
//           timeout, implicit release, wrap-around).
// Timing  : inputs driven 1 time unit after each rising edge, outputs sampled at that point.
// Result  : one summary line with assertion and failure counts.
module tb_pri_rr_sched;

    localparam int W  = 56;
    localparam int WL = 6;

    logic          clk;
    logic          rst_n;
    logic [W-1:0]  req;
    logic          release_gnt;
    logic [W-1:0]  gnt;
    logic [WL-1:0] gnt_id;
    logic          gnt_valid;
    logic          timeout;

    int n_checks = 0;
    int n_fail   = 0;

    pri_rr_sched #(
        .WIDTH     (W),
        .WIDTH_LOG (WL),
        .MAX_HOLD  (15)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .release_gnt (release_gnt),
        .gnt         (gnt),
        .gnt_id      (gnt_id),
        .gnt_valid   (gnt_valid),
        .timeout     (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        req         = '0;
        release_gnt = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        logic [W-1:0] exp;
        rst_n       = 1'b0;
        req         = '0;
        release_gnt = 1'b0;
        #1;
        n_checks++;
        if (gnt !== '0) begin n_fail++; $display("FAIL reset_gnt: got %h want 0", gnt); end
        n_checks++;
        if (gnt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", gnt_valid); end
        n_checks++;
        if (gnt_id !== '0) begin n_fail++; $display("FAIL reset_id: got %0d want 0", gnt_id); end
        n_checks++;
        if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", timeout); end
        step();
        rst_n = 1'b1;
        // Build a mask state of "below 40", then reset mid-grant.
        req = '0; req[40] = 1'b1; req[17] = 1'b1;
        step();
        n_checks++;
        if (gnt_id !== 6'd40) begin n_fail++; $display("FAIL rst_pre_grant40: got %0d want 40", gnt_id); end
        release_gnt = 1'b1;
        step();
        release_gnt = 1'b0;
        n_checks++;
        if (gnt_id !== 6'd17) begin n_fail++; $display("FAIL rst_pre_grant17: got %0d want 17", gnt_id); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (gnt !== '0) begin n_fail++; $display("FAIL rst_async_gnt: got %h want 0", gnt); end
        n_checks++;
        if (gnt_valid !== 1'b0) begin n_fail++; $display("FAIL rst_async_valid: got %b want 0", gnt_valid); end
        step();
        rst_n = 1'b1;
        // With mask back to all-ones, 40 must win over 17.
        step();
        exp = '0; exp[40] = 1'b1;
        n_checks++;
        if (gnt_id !== 6'd40) begin n_fail++; $display("FAIL rst_mask_allones: got %0d want 40", gnt_id); end
        n_checks++;
        if (gnt !== exp) begin n_fail++; $display("FAIL rst_mask_gnt: got %h want %h", gnt, exp); end
        req = '0;
        step();
        step();
    endtask

    task automatic test_priority();
        logic [W-1:0] exp;
        do_reset();
        req = '0; req[3] = 1'b1; req[40] = 1'b1; req[17] = 1'b1;
        n_checks++;
        if (gnt_valid !== 1'b0) begin n_fail++; $display("FAIL prio_idle: got %b want 0", gnt_valid); end
        step();
        exp = '0; exp[40] = 1'b1;
        n_checks++;
        if (gnt_id !== 6'd40) begin n_fail++; $display("FAIL prio_id: got %0d want 40", gnt_id); end
        n_checks++;
        if (gnt !== exp) begin n_fail++; $display("FAIL prio_gnt: got %h want %h", gnt, exp); end
        n_checks++;
        if (gnt_valid !== 1'b1) begin n_fail++; $display("FAIL prio_valid: got %b want 1", gnt_valid); end
    endtask

    task automatic test_round_robin();
        logic [WL-1:0] exp_seq [5];
        logic [W-1:0]  exp;
        exp_seq[0] = 6'd17; exp_seq[1] = 6'd3; exp_seq[2] = 6'd40;
        exp_seq[3] = 6'd17; exp_seq[4] = 6'd3;
        // Continues from test_priority with 40 granted and {3,17,40} held.
        release_gnt = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            exp = '0; exp[exp_seq[k]] = 1'b1;
            n_checks++;
            if (gnt_id !== exp_seq[k]) begin
                n_fail++; $display("FAIL rr_id[%0d]: got %0d want %0d", k, gnt_id, exp_seq[k]);
            end
            n_checks++;
            if (gnt !== exp || gnt_valid !== 1'b1) begin
                n_fail++; $display("FAIL rr_gnt[%0d]: got %h/%b want %h/1", k, gnt, gnt_valid, exp);
            end
        end
        release_gnt = 1'b0;
        req = '0;
        step();
        n_checks++;
        if (gnt_valid !== 1'b0 || gnt !== '0) begin
            n_fail++; $display("FAIL rr_idle: got %h/%b want 0/0", gnt, gnt_valid);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        req = '0; req[5] = 1'b1;
        step();
        n_checks++;
        if (gnt_id !== 6'd5 || gnt_valid !== 1'b1) begin
            n_fail++; $display("FAIL to_grant: got %0d/%b want 5/1", gnt_id, gnt_valid);
        end
        // Cycles 2..15 of the grant: still held, no pulse yet.
        for (int k = 1; k < 15; k++) begin
            step();
            n_checks++;
            if (gnt_valid !== 1'b1 || gnt_id !== 6'd5 || timeout !== 1'b0) begin
                n_fail++;
                $display("FAIL to_hold[%0d]: got id=%0d vld=%b to=%b want 5/1/0", k, gnt_id, gnt_valid, timeout);
            end
        end
        step();
        n_checks++;
        if (timeout !== 1'b1) begin n_fail++; $display("FAIL to_pulse: got %b want 1", timeout); end
        n_checks++;
        if (gnt_id !== 6'd5 || gnt_valid !== 1'b1) begin
            n_fail++; $display("FAIL to_regrant: got %0d/%b want 5/1", gnt_id, gnt_valid);
        end
        step();
        n_checks++;
        if (timeout !== 1'b0) begin n_fail++; $display("FAIL to_pulse_width: got %b want 0", timeout); end
        req = '0;
        step();
        n_checks++;
        if (gnt_valid !== 1'b0 || timeout !== 1'b0) begin
            n_fail++; $display("FAIL to_idle: got %b/%b want 0/0", gnt_valid, timeout);
        end
    endtask

    task automatic test_implicit_release();
        logic [W-1:0] exp;
        req = '0; req[55] = 1'b1;
        step();
        exp = '0; exp[55] = 1'b1;
        n_checks++;
        if (gnt !== exp || gnt_id !== 6'd55) begin
            n_fail++; $display("FAIL impl_grant: got %h/%0d want %h/55", gnt, gnt_id, exp);
        end
        req = '0;
        release_gnt = 1'b1;
        step();
        release_gnt = 1'b0;
        n_checks++;
        if (gnt !== '0 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
            n_fail++; $display("FAIL impl_drop: got %h/%b/%b want 0/0/0", gnt, gnt_valid, timeout);
        end
        step();
        n_checks++;
        if (gnt_valid !== 1'b0) begin n_fail++; $display("FAIL impl_stay_idle: got %b want 0", gnt_valid); end
    endtask

    task automatic test_wrap();
        do_reset();
        req = '0; req[0] = 1'b1;
        step();
        n_checks++;
        if (gnt_id !== 6'd0 || gnt_valid !== 1'b1) begin
            n_fail++; $display("FAIL wrap_grant0: got %0d/%b want 0/1", gnt_id, gnt_valid);
        end
        req[54] = 1'b1;
        release_gnt = 1'b1;
        step();
        n_checks++;
        if (gnt_id !== 6'd54 || gnt_valid !== 1'b1) begin
            n_fail++; $display("FAIL wrap_fallback: got %0d/%b want 54/1", gnt_id, gnt_valid);
        end
        // Ending 54 masks to indices below 54, so 0 comes next.
        step();
        release_gnt = 1'b0;
        n_checks++;
        if (gnt_id !== 6'd0 || gnt_valid !== 1'b1) begin
            n_fail++; $display("FAIL wrap_next0: got %0d/%b want 0/1", gnt_id, gnt_valid);
        end
        req = '0;
        step();
    endtask

    initial begin
        test_reset();
        test_priority();
        test_round_robin();
        test_timeout();
        test_implicit_release();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
